// File: rtl/dp_bram_pipe.sv
// Dual-port block RAM with valid/ready handshakes, 1..3 cycle read latency,
// read-during-write mode, out-of-range detection and a clear engine.
// Optional access counters are compiled in with `define DP_BRAM_STATS_EN.
module dp_bram_pipe #(
   parameter int AddrWidth   = 10,
   parameter int DataSize    = 16,
   parameter int Depth       = 1024,
   parameter int ReadLatency = 1,
   parameter int RdwMode     = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   output logic                 busy_o,
   input  logic                 wvalid_i,
   output logic                 wready_o,
   input  logic [AddrWidth-1:0] waddr_i,
   input  logic [DataSize-1:0]  wdata_i,
   input  logic                 rvalid_i,
   output logic                 rready_o,
   input  logic [AddrWidth-1:0] raddr_i,
   output logic [DataSize-1:0]  rdata_o,
   output logic                 rdata_valid_o,
   output logic                 oob_o,
   output logic [31:0]          wr_count_o,
   output logic [31:0]          rd_count_o
);

   localparam logic [AddrWidth:0] DEPTH_W = (AddrWidth+1)'(Depth);
   localparam logic [AddrWidth:0] LAST_W  = (AddrWidth+1)'(Depth - 1);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t               state_reg, state_next;
   logic [AddrWidth-1:0] cnt_reg, cnt_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= ST_CLEAR;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_CLEAR: begin
            cnt_next = cnt_reg + 1'b1;
            if ({1'b0, cnt_reg} == LAST_W) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end
         end
         ST_IDLE: begin
            if (clear_i) begin
               state_next = ST_CLEAR;
               cnt_next   = '0;
            end
         end
         default: state_next = ST_CLEAR;
      endcase
   end

   assign busy_o   = (state_reg == ST_CLEAR);
   assign wready_o = !busy_o;
   assign rready_o = !busy_o;

   logic wr_acc, rd_acc, wr_oob, rd_oob, wr_in_range, bypass;

   assign wr_acc      = wvalid_i && wready_o;
   assign rd_acc      = rvalid_i && rready_o;
   assign wr_oob      = ({1'b0, waddr_i} >= DEPTH_W);
   assign rd_oob      = ({1'b0, raddr_i} >= DEPTH_W);
   assign wr_in_range = wr_acc && !wr_oob;
   assign bypass      = (RdwMode != 0) && wr_in_range && (waddr_i == raddr_i);

   // Clear-engine and user writes share the single RAM write port; they never overlap.
   logic                 mem_we;
   logic [AddrWidth-1:0] mem_waddr;
   logic [DataSize-1:0]  mem_wdata;

   assign mem_we    = !rst_i && (busy_o || wr_in_range);
   assign mem_waddr = busy_o ? cnt_reg : waddr_i;
   assign mem_wdata = busy_o ? '0 : wdata_i;

   logic [DataSize-1:0] mem [Depth];
   logic [DataSize-1:0] ram_q_reg;

   always_ff @(posedge clk_i) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk_i) begin
      if (rd_acc)
         ram_q_reg <= mem[raddr_i];
   end

   // Side-band flags travel with the RAM output so the RAM read stays a plain registered read.
   logic                v0_reg, zero_reg, byp_reg;
   logic [DataSize-1:0] byp_data_reg;
   logic [DataSize-1:0] rd_data0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v0_reg       <= 1'b0;
         zero_reg     <= 1'b1;
         byp_reg      <= 1'b0;
         byp_data_reg <= '0;
      end else begin
         v0_reg <= rd_acc;
         if (rd_acc) begin
            zero_reg     <= rd_oob;
            byp_reg      <= bypass;
            byp_data_reg <= wdata_i;
         end
      end
   end

   assign rd_data0 = zero_reg ? '0 : (byp_reg ? byp_data_reg : ram_q_reg);

   wire [DataSize-1:0]    chain_data [ReadLatency];
   wire [ReadLatency-1:0] chain_vld;

   assign chain_data[0] = rd_data0;
   assign chain_vld[0]  = v0_reg;

   genvar gi;
   for (gi = 1; gi < ReadLatency; gi++) begin : g_stage
      logic [DataSize-1:0] data_reg;
      logic                vld_reg;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            data_reg <= '0;
            vld_reg  <= 1'b0;
         end else begin
            vld_reg <= chain_vld[gi-1];
            if (chain_vld[gi-1])
               data_reg <= chain_data[gi-1];
         end
      end

      assign chain_data[gi] = data_reg;
      assign chain_vld[gi]  = vld_reg;
   end

   assign rdata_o       = chain_data[ReadLatency-1];
   assign rdata_valid_o = chain_vld[ReadLatency-1];

   logic oob_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         oob_reg <= 1'b0;
      else if ((wr_acc && wr_oob) || (rd_acc && rd_oob))
         oob_reg <= 1'b1;
   end

   assign oob_o = oob_reg;

`ifdef DP_BRAM_STATS_EN
   logic [31:0] wr_count_reg, rd_count_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_count_reg <= '0;
         rd_count_reg <= '0;
      end else begin
         if (wr_in_range)
            wr_count_reg <= wr_count_reg + 32'd1;
         if (rd_acc)
            rd_count_reg <= rd_count_reg + 32'd1;
      end
   end

   assign wr_count_o = wr_count_reg;
   assign rd_count_o = rd_count_reg;
`else
   assign wr_count_o = '0;
   assign rd_count_o = '0;
`endif

endmodule

// File: tb/tb_dp_bram_pipe.sv
// Directed bench for dp_bram_pipe: instance a is the default build (Depth 1024,
// latency 1, read-first); instance b uses Depth 1000, latency 3, write-first.
module tb_dp_bram_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef DP_BRAM_STATS_EN
   localparam int EXP_WR = 5;
   localparam int EXP_RD = 3;
`else
   localparam int EXP_WR = 0;
   localparam int EXP_RD = 0;
`endif

   logic        a_rst, a_clear, a_busy, a_wvalid, a_wready, a_rvalid, a_rready;
   logic [9:0]  a_waddr, a_raddr;
   logic [15:0] a_wdata, a_rdata;
   logic        a_rdv, a_oob;
   logic [31:0] a_wrc, a_rdc;

   logic        b_rst, b_clear, b_busy, b_wvalid, b_wready, b_rvalid, b_rready;
   logic [9:0]  b_waddr, b_raddr;
   logic [15:0] b_wdata, b_rdata;
   logic        b_rdv, b_oob;
   logic [31:0] b_wrc, b_rdc;

   dp_bram_pipe u_a (
      .clk_i(clk), .rst_i(a_rst), .clear_i(a_clear), .busy_o(a_busy),
      .wvalid_i(a_wvalid), .wready_o(a_wready), .waddr_i(a_waddr), .wdata_i(a_wdata),
      .rvalid_i(a_rvalid), .rready_o(a_rready), .raddr_i(a_raddr), .rdata_o(a_rdata),
      .rdata_valid_o(a_rdv), .oob_o(a_oob), .wr_count_o(a_wrc), .rd_count_o(a_rdc)
   );

   dp_bram_pipe #(
      .AddrWidth(10), .DataSize(16), .Depth(1000), .ReadLatency(3), .RdwMode(1)
   ) u_b (
      .clk_i(clk), .rst_i(b_rst), .clear_i(b_clear), .busy_o(b_busy),
      .wvalid_i(b_wvalid), .wready_o(b_wready), .waddr_i(b_waddr), .wdata_i(b_wdata),
      .rvalid_i(b_rvalid), .rready_o(b_rready), .raddr_i(b_raddr), .rdata_o(b_rdata),
      .rdata_valid_o(b_rdv), .oob_o(b_oob), .wr_count_o(b_wrc), .rd_count_o(b_rdc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [9:0] ad, input logic [15:0] d);
      a_wvalid = 1'b1; a_waddr = ad; a_wdata = d;
      tick();
      a_wvalid = 1'b0;
      $display("[TB] a write addr=%0d data=%h", ad, d);
   endtask

   task automatic b_write(input logic [9:0] ad, input logic [15:0] d);
      b_wvalid = 1'b1; b_waddr = ad; b_wdata = d;
      tick();
      b_wvalid = 1'b0;
      $display("[TB] b write addr=%0d data=%h", ad, d);
   endtask

   task automatic a_read(input logic [9:0] ad, output logic [15:0] d, output logic v);
      a_rvalid = 1'b1; a_raddr = ad;
      tick();
      a_rvalid = 1'b0;
      d = a_rdata; v = a_rdv;
      $display("[TB] a read addr=%0d data=%h valid=%0b", ad, d, v);
   endtask

   task automatic b_read(input logic [9:0] ad, output logic [15:0] d, output logic v);
      b_rvalid = 1'b1; b_raddr = ad;
      tick();
      b_rvalid = 1'b0;
      tick();
      tick();
      d = b_rdata; v = b_rdv;
      $display("[TB] b read addr=%0d data=%h valid=%0b", ad, d, v);
   endtask

   task automatic test_reset();
      int n, bad;
      logic [15:0] d;
      logic v;
      a_rst = 1'b1; b_rst = 1'b1;
      tick();
      a_rst = 1'b0; b_rst = 1'b0;
      n_tests++;
      if ({a_busy, a_wready, a_rready, a_rdv, a_oob} !== 5'b10000) begin
         n_fail++; $display("FAIL reset_ctrl got %b want 10000", {a_busy, a_wready, a_rready, a_rdv, a_oob});
      end
      n_tests++;
      if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
         n_fail++; $display("FAIL reset_rdata got a=%h b=%h want 0", a_rdata, b_rdata);
      end
      n_tests++;
      if (a_wrc !== 32'd0 || a_rdc !== 32'd0 || b_rdv !== 1'b0) begin
         n_fail++; $display("FAIL reset_cnt got wr=%0d rd=%0d bv=%b want 0", a_wrc, a_rdc, b_rdv);
      end
      n = 0; bad = 0;
      while (a_busy && n < 3000) begin
         if (a_wready || a_rready) bad++;
         n++;
         tick();
      end
      n_tests++;
      if (n !== 1024) begin
         n_fail++; $display("FAIL reset_busy_len got %0d want 1024", n);
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL reset_ready_low got %0d ready cycles want 0", bad);
      end
      a_read(10'd5, d, v);
      n_tests++;
      if (v !== 1'b1 || d !== 16'h0) begin
         n_fail++; $display("FAIL reset_read5 got v=%b d=%h want v=1 d=0000", v, d);
      end
      tick();
      n_tests++;
      if (a_rdv !== 1'b0) begin
         n_fail++; $display("FAIL reset_read5_pulse got v=%b want 0", a_rdv);
      end
   endtask

   task automatic test_rdw_old();
      logic [15:0] d;
      logic v;
      a_write(10'd9, 16'h00AA);
      a_wvalid = 1'b1; a_waddr = 10'd9; a_wdata = 16'h1234;
      a_rvalid = 1'b1; a_raddr = 10'd9;
      tick();
      a_wvalid = 1'b0; a_rvalid = 1'b0;
      n_tests++;
      if (a_rdv !== 1'b1 || a_rdata !== 16'h00AA) begin
         n_fail++; $display("FAIL rdw_old got v=%b d=%h want v=1 d=00aa", a_rdv, a_rdata);
      end
      a_wvalid = 1'b1; a_waddr = 10'd10; a_wdata = 16'h5555;
      a_rvalid = 1'b1; a_raddr = 10'd9;
      tick();
      a_wvalid = 1'b0; a_rvalid = 1'b0;
      n_tests++;
      if (a_rdv !== 1'b1 || a_rdata !== 16'h1234) begin
         n_fail++; $display("FAIL rdw_diff_addr got v=%b d=%h want v=1 d=1234", a_rdv, a_rdata);
      end
      a_read(10'd10, d, v);
      n_tests++;
      if (v !== 1'b1 || d !== 16'h5555) begin
         n_fail++; $display("FAIL rdw_other_write got v=%b d=%h want v=1 d=5555", v, d);
      end
   endtask

   task automatic test_latency3();
      b_write(10'd7, 16'hBEEF);
      b_rvalid = 1'b1; b_raddr = 10'd7;
      tick();
      b_rvalid = 1'b0;
      n_tests++;
      if (b_rdv !== 1'b0) begin
         n_fail++; $display("FAIL lat3_c1 got v=%b want 0", b_rdv);
      end
      tick();
      n_tests++;
      if (b_rdv !== 1'b0) begin
         n_fail++; $display("FAIL lat3_c2 got v=%b want 0", b_rdv);
      end
      tick();
      n_tests++;
      if (b_rdv !== 1'b1 || b_rdata !== 16'hBEEF) begin
         n_fail++; $display("FAIL lat3_c3 got v=%b d=%h want v=1 d=beef", b_rdv, b_rdata);
      end
      tick();
      n_tests++;
      if (b_rdv !== 1'b0 || b_rdata !== 16'hBEEF) begin
         n_fail++; $display("FAIL lat3_hold got v=%b d=%h want v=0 d=beef", b_rdv, b_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_d;
      for (int i = 0; i < 4; i++) b_write(10'(20 + i), 16'(16'h1000 + i));
      for (int k = 0; k < 8; k++) begin
         b_rvalid = (k < 4);
         b_raddr  = 10'(20 + k);
         tick();
         b_rvalid = 1'b0;
         exp_d = 16'(16'h1000 + k - 2);
         n_tests++;
         if (k >= 2 && k < 6) begin
            if (b_rdv !== 1'b1 || b_rdata !== exp_d) begin
               n_fail++; $display("FAIL b2b_%0d got v=%b d=%h want v=1 d=%h", k, b_rdv, b_rdata, exp_d);
            end
         end else if (b_rdv !== 1'b0) begin
            n_fail++; $display("FAIL b2b_%0d got v=%b want 0", k, b_rdv);
         end
      end
   endtask

   task automatic test_rdw_new();
      b_write(10'd9, 16'h00AA);
      b_wvalid = 1'b1; b_waddr = 10'd9; b_wdata = 16'h1234;
      b_rvalid = 1'b1; b_raddr = 10'd9;
      tick();
      b_wvalid = 1'b0; b_rvalid = 1'b0;
      tick();
      tick();
      n_tests++;
      if (b_rdv !== 1'b1 || b_rdata !== 16'h1234) begin
         n_fail++; $display("FAIL rdw_new got v=%b d=%h want v=1 d=1234", b_rdv, b_rdata);
      end
   endtask

   task automatic test_oob();
      logic [15:0] d;
      logic v;
      b_write(10'd999, 16'h0999);
      b_read(10'd999, d, v);
      n_tests++;
      if (v !== 1'b1 || d !== 16'h0999 || b_oob !== 1'b0) begin
         n_fail++; $display("FAIL oob_last_addr got v=%b d=%h oob=%b want 1 0999 0", v, d, b_oob);
      end
      b_write(10'd1010, 16'h7777);
      n_tests++;
      if (b_oob !== 1'b1) begin
         n_fail++; $display("FAIL oob_write_flag got %b want 1", b_oob);
      end
      b_read(10'd1010, d, v);
      n_tests++;
      if (v !== 1'b1 || d !== 16'h0) begin
         n_fail++; $display("FAIL oob_read got v=%b d=%h want v=1 d=0000", v, d);
      end
      b_read(10'd10, d, v);
      n_tests++;
      if (v !== 1'b1 || d !== 16'h0 || b_oob !== 1'b1) begin
         n_fail++; $display("FAIL oob_no_alias got v=%b d=%h oob=%b want 1 0000 1", v, d, b_oob);
      end
      n_tests++;
      if (a_oob !== 1'b0) begin
         n_fail++; $display("FAIL oob_inrange_a got %b want 0", a_oob);
      end
   endtask

   task automatic test_clear();
      int n, bad;
      for (int i = 0; i < 4; i++) a_write(10'(i), 16'(16'h1111 * (i + 1)));
      a_clear = 1'b1; a_rvalid = 1'b1; a_raddr = 10'd0;
      tick();
      n_tests++;
      if (a_rdv !== 1'b1 || a_rdata !== 16'h1111 || a_busy !== 1'b1) begin
         n_fail++; $display("FAIL clear_inflight got v=%b d=%h busy=%b want 1 1111 1", a_rdv, a_rdata, a_busy);
      end
      n = 0; bad = 0;
      while (a_busy && n < 3000) begin
         n++;
         if (n == 3) a_clear = 1'b0;
         tick();
         if (a_rdv) bad++;
      end
      n_tests++;
      if (n !== 1024) begin
         n_fail++; $display("FAIL clear_busy_len got %0d want 1024", n);
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL clear_no_accept got %0d results want 0", bad);
      end
      for (int i = 0; i < 4; i++) begin
         a_raddr = 10'(i);
         tick();
         n_tests++;
         if (a_rdv !== 1'b1 || a_rdata !== 16'h0) begin
            n_fail++; $display("FAIL clear_read_%0d got v=%b d=%h want v=1 d=0000", i, a_rdv, a_rdata);
         end
      end
      a_rvalid = 1'b0;
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      repeat (500) tick();
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      n = 0;
      while (a_busy && n < 3000) begin
         n++;
         tick();
      end
      n_tests++;
      if (n !== 1024) begin
         n_fail++; $display("FAIL clear_rst_restart got %0d want 1024", n);
      end
   endtask

   task automatic test_stats();
      int n;
      b_rst = 1'b1;
      tick();
      b_rst = 1'b0;
      n_tests++;
      if (b_oob !== 1'b0 || b_wrc !== 32'd0 || b_rdc !== 32'd0) begin
         n_fail++; $display("FAIL stats_rst got oob=%b wr=%0d rd=%0d want 0 0 0", b_oob, b_wrc, b_rdc);
      end
      n = 0;
      while (b_busy && n < 3000) begin
         n++;
         tick();
      end
      n_tests++;
      if (n !== 1000) begin
         n_fail++; $display("FAIL stats_busy_len got %0d want 1000", n);
      end
      for (int i = 0; i < 5; i++) b_write(10'(100 + i), 16'(i + 1));
      b_write(10'd1005, 16'hDEAD);
      b_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b_raddr = 10'(100 + i);
         tick();
      end
      b_rvalid = 1'b0;
      repeat (4) tick();
      n_tests++;
      if (b_wrc !== 32'(EXP_WR) || b_rdc !== 32'(EXP_RD) || b_oob !== 1'b1) begin
         n_fail++; $display("FAIL stats_counts got wr=%0d rd=%0d oob=%b want %0d %0d 1", b_wrc, b_rdc, b_oob, EXP_WR, EXP_RD);
      end
      b_clear = 1'b1;
      tick();
      b_clear = 1'b0;
      n = 0;
      while (b_busy && n < 3000) begin
         n++;
         tick();
      end
      n_tests++;
      if (b_wrc !== 32'(EXP_WR) || b_rdc !== 32'(EXP_RD) || b_oob !== 1'b1 || n !== 1000) begin
         n_fail++; $display("FAIL stats_after_clear got wr=%0d rd=%0d oob=%b busy=%0d want %0d %0d 1 1000", b_wrc, b_rdc, b_oob, n, EXP_WR, EXP_RD);
      end
   endtask

   initial begin
      a_rst = 1'b0; a_clear = 1'b0; a_wvalid = 1'b0; a_rvalid = 1'b0;
      a_waddr = '0; a_raddr = '0; a_wdata = '0;
      b_rst = 1'b0; b_clear = 1'b0; b_wvalid = 1'b0; b_rvalid = 1'b0;
      b_waddr = '0; b_raddr = '0; b_wdata = '0;
      test_reset();
      test_rdw_old();
      test_latency3();
      test_back_to_back();
      test_rdw_new();
      test_oob();
      test_clear();
      test_stats();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dp_bram_pipe.md
Name: dp_bram_pipe

Overview:
- Parametrised successor to the team's simple dual-port block RAM: one write port and one read port in a single clock domain.
- Adds valid/ready handshakes, configurable read latency, selectable read-during-write mode, non-power-of-two depth with out-of-range detection, and a hardware clear engine.
- The clear engine zeroes the whole array after reset or on request.
- Used as coefficient and delay-line storage in the FIR datapath.

Parameters:
- AddrWidth, 10, width of address ports.
- DataSize, 16, width of one word in bits.
- Depth, 1024, number of words; must satisfy 1 <= Depth <= 2**AddrWidth.
- ReadLatency, 1, cycles from accepted read to rdata_valid_o; legal range 1..3.
- RdwMode, 0, same-address read-during-write result: 0 = old data (read-first), 1 = new data (write-first).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  one-cycle request to zero the array; honoured only in IDLE.
- busy_o  out  1  high while the clear engine runs.
- wvalid_i  in  1  write request.
- wready_o  out  1  write port can accept (= !busy_o).
- waddr_i  in  AddrWidth  write address.
- wdata_i  in  DataSize  write data.
- rvalid_i  in  1  read request.
- rready_o  out  1  read port can accept (= !busy_o).
- raddr_i  in  AddrWidth  read address.
- rdata_o  out  DataSize  read data.
- rdata_valid_o  out  1  rdata_o valid this cycle.
- oob_o  out  1  sticky flag: an accepted access used address >= Depth.
- wr_count_o  out  32  accepted in-range writes (optional feature).
- rd_count_o  out  32  accepted reads (optional feature).

Behaviour:
- Reset (rst_i=1 at an edge):
  - FSM enters CLEAR; clear counter = 0; busy_o=1.
  - wready_o=rready_o=0, rdata_o=0, rdata_valid_o=0, oob_o=0.
  - Read pipeline valid bits flushed; counters = 0.
  - Reset asserted mid-clear restarts the clear from address 0.
- FSM states:
  - CLEAR: writes 0 to address cnt each cycle, cnt++. After writing Depth-1 (Depth cycles total), go to IDLE next cycle; busy_o falls on that edge.
  - IDLE: clear_i=1 moves to CLEAR with cnt=0. clear_i is ignored while already in CLEAR.
- Handshakes:
  - Write accepted when wvalid_i && wready_o; read accepted when rvalid_i && rready_o.
  - Requests presented while busy_o=1 are not accepted; the requester must hold them.
  - Write and read may be accepted in the same cycle.
- Write: the array is updated at the accepting edge when waddr_i < Depth. An out-of-range write is dropped and sets oob_o.
- Read:
  - rdata_valid_o pulses exactly ReadLatency cycles after the accepting edge (ReadLatency=1 is standard BRAM timing).
  - Back-to-back reads give one result per cycle, in order.
  - An out-of-range read returns 0 with valid asserted and sets oob_o.
  - rdata_o holds its last value while rdata_valid_o=0.
- Read-during-write, same address, same cycle:
  - RdwMode=0: returns the pre-write contents.
  - RdwMode=1: returns wdata_i.
  - Different addresses are independent.
- Reads in flight when CLEAR starts complete normally with their sampled data. Reads accepted after clear completion return 0 for every address.
- oob_o clears only on rst_i.
- Storage: one block-RAM inference of Depth x DataSize. Extra latency stages are flops after the RAM output.

Optional Feature:
- Macro: DP_BRAM_STATS_EN.
- Defined:
  - wr_count_o increments on each accepted in-range write.
  - rd_count_o increments on each accepted read.
  - Both wrap modulo 2**32, are cleared by rst_i, and are not cleared by clear_i.
  - Clear-engine writes are not counted.
- Undefined: both outputs tied to 0; no counter flops are synthesised.

Test Plan:
- Reset with Depth=1024 -> busy_o high exactly 1024 cycles, ready low during that time; then a read of addr 5 returns 0 with rdata_valid_o one cycle later (ReadLatency=1).
- ReadLatency=3: write 0xBEEF to addr 7, then read addr 7 -> rdata_o=0xBEEF, valid exactly 3 cycles after acceptance; 4 back-to-back reads return 4 in-order results on consecutive cycles.
- Same-cycle write 0x1234 and read of addr 9, which holds 0x00AA -> RdwMode=0 returns 0x00AA, RdwMode=1 returns 0x1234.
- Depth=1000, AddrWidth=10: write to addr 1010, then read addr 1010 -> write dropped, read returns 0, oob_o=1 and stays set until rst_i.
- Fill addrs 0..3 with nonzero data, pulse clear_i, assert rvalid_i throughout -> busy_o high for Depth cycles, no reads accepted while busy_o=1, subsequent reads of 0..3 return 0; rst_i mid-clear restarts the full Depth-cycle sequence.
- With DP_BRAM_STATS_EN: 5 in-range writes, 1 out-of-range write, 3 reads -> wr_count_o=5, rd_count_o=3; unchanged after clear_i.
